// File: rtl/cpu_irq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_irq_arbiter
//  Description : Round-robin interrupt arbiter feeding the CPU external
//                interrupt input. Software claims an interrupt by reading
//                CLAIM and completes it by writing the claimed id back.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_irq_arbiter #(
   parameter int SOURCES = 8
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic [SOURCES-1:0] i_sources,
   input  logic               i_request,
   input  logic               i_rw,
   input  logic [3:0]         i_address,
   input  logic [31:0]        i_wdata,
   output logic [31:0]        o_rdata,
   output logic               o_ready,
   output logic               o_interrupt
);

   localparam int         c_ID_W         = 5;
   localparam logic [5:0] c_NSRC         = 6'(SOURCES);
   localparam logic [4:0] c_LAST         = 5'(SOURCES - 1);
   localparam logic [1:0] c_ADDR_PENDING = 2'd0;
   localparam logic [1:0] c_ADDR_ENABLE  = 2'd1;
   localparam logic [1:0] c_ADDR_CLAIM   = 2'd2;
   localparam logic [1:0] c_ADDR_STATUS  = 2'd3;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } state_t;

   state_t              r_state;
   logic                r_ready;
   logic [31:0]         r_rdata;
   logic [SOURCES-1:0]  r_sync1;
   logic [SOURCES-1:0]  r_sync2;
   logic [SOURCES-1:0]  r_sync3;
   logic [SOURCES-1:0]  r_pending;
   logic [SOURCES-1:0]  r_enable;
   logic                r_in_service;
   logic [c_ID_W-1:0]   r_svc_id;
   logic [c_ID_W-1:0]   r_rr_ptr;
   logic                r_irq;

   logic [SOURCES-1:0]   w_edge;
   logic [SOURCES-1:0]   w_active;
   logic                 w_any;
   logic [2*SOURCES-1:0] w_dbl_sh;
   logic [SOURCES-1:0]   w_rot;
   logic [c_ID_W-1:0]    w_off;
   logic [c_ID_W:0]      w_sum;
   logic [c_ID_W:0]      w_win6;
   logic [c_ID_W-1:0]    w_win;
   logic [c_ID_W-1:0]    w_win_id;
   logic [c_ID_W-1:0]    w_next_ptr;
   logic [SOURCES-1:0]   w_onehot;
   logic                 w_access;
   logic [1:0]           w_sel;
   logic                 w_claim_ok;
   logic                 w_complete;
   logic                 w_w1c;
   logic                 w_en_wr;
   logic [SOURCES-1:0]   w_clr;
   logic [31:0]          w_rdata;
   logic                 w_unused;

   assign w_edge   = r_sync2 & ~r_sync3;
   assign w_active = r_pending & r_enable;
   assign w_any    = |w_active;

   // Rotate the candidate vector so that bit 0 corresponds to rr_ptr.
   assign w_dbl_sh = {w_active, w_active} >> r_rr_ptr;
   assign w_rot    = w_dbl_sh[SOURCES-1:0];

   // Lowest set bit of the rotated vector is the offset from rr_ptr.
   always_comb begin
      w_off = '0;
      for (int j = SOURCES - 1; j >= 0; j--) begin
         if (w_rot[j]) begin
            w_off = 5'(j);
         end
      end
   end

   assign w_sum      = {1'b0, r_rr_ptr} + {1'b0, w_off};
   assign w_win6     = (w_sum >= c_NSRC) ? (w_sum - c_NSRC) : w_sum;
   assign w_win      = w_win6[c_ID_W-1:0];
   assign w_win_id   = w_win + 5'd1;
   assign w_next_ptr = (w_win == c_LAST) ? 5'd0 : w_win_id;

   // One-hot mask of the winning source, used to clear its pending bit.
   always_comb begin
      w_onehot = '0;
      for (int i = 0; i < SOURCES; i++) begin
         w_onehot[i] = (w_win == 5'(i));
      end
   end

   // Access decode: side effects only on the IDLE->ACK transition.
   assign w_access   = (r_state == ST_IDLE) && i_request;
   assign w_sel      = i_address[3:2];
   assign w_claim_ok = w_access && !i_rw && (w_sel == c_ADDR_CLAIM) && !r_in_service && w_any;
   assign w_complete = w_access && i_rw && (w_sel == c_ADDR_CLAIM) && r_in_service
                       && (i_wdata[4:0] == r_svc_id);
   assign w_w1c      = w_access && i_rw && (w_sel == c_ADDR_PENDING);
   assign w_en_wr    = w_access && i_rw && (w_sel == c_ADDR_ENABLE);
   assign w_clr      = (w_w1c ? i_wdata[SOURCES-1:0] : '0) | (w_claim_ok ? w_onehot : '0);

   // Read data mux; a refused claim reads as zero.
   always_comb begin
      w_rdata = '0;
      case (w_sel)
         c_ADDR_PENDING: w_rdata = 32'(r_pending);
         c_ADDR_ENABLE:  w_rdata = 32'(r_enable);
         c_ADDR_CLAIM:   w_rdata = w_claim_ok ? 32'(w_win_id) : 32'd0;
         c_ADDR_STATUS:  w_rdata = {r_in_service, 26'b0, r_svc_id};
         default:        w_rdata = '0;
      endcase
   end

   // Two-flop synchroniser plus a third stage for rising-edge detection.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_sync3 <= '0;
      end else begin
         r_sync1 <= i_sources;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   // Pending bits: a fresh edge always wins over a same-cycle clear.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_pending <= '0;
      end else begin
         r_pending <= (r_pending & ~w_clr) | w_edge;
      end
   end

   // Enable register.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_enable <= '0;
      end else if (w_en_wr) begin
         r_enable <= i_wdata[SOURCES-1:0];
      end
   end

   // In-service tracking and round-robin pointer update.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_in_service <= 1'b0;
         r_svc_id     <= '0;
         r_rr_ptr     <= '0;
      end else if (w_claim_ok) begin
         r_in_service <= 1'b1;
         r_svc_id     <= w_win_id;
         r_rr_ptr     <= w_next_ptr;
      end else if (w_complete) begin
         r_in_service <= 1'b0;
         r_svc_id     <= '0;
      end
   end

   // Registered interrupt request towards the CPU.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= w_any & ~r_in_service;
      end
   end

   // Bus handshake FSM: one access per request, ack held until request drops.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= ST_IDLE;
         r_ready <= 1'b0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_request) begin
                  r_state <= ST_ACK;
                  r_ready <= 1'b1;
                  r_rdata <= i_rw ? 32'd0 : w_rdata;
               end
            end
            ST_ACK: begin
               if (!i_request) begin
                  r_state <= ST_IDLE;
                  r_ready <= 1'b0;
                  r_rdata <= '0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b0;
               r_rdata <= '0;
            end
         endcase
      end
   end

   assign o_ready     = r_ready;
   assign o_rdata     = r_rdata;
   assign o_interrupt = r_irq;

   // Address byte-lane bits and spare data/rotation bits are intentionally ignored.
   assign w_unused = ^{i_address[1:0], i_wdata, w_dbl_sh, w_win6};

endmodule
`default_nettype wire

// File: tb/tb_cpu_irq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_irq_arbiter
//  Description : Directed self-checking bench for cpu_irq_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_irq_arbiter;

   localparam logic [3:0] c_A_PEND   = 4'h0;
   localparam logic [3:0] c_A_EN     = 4'h4;
   localparam logic [3:0] c_A_CLAIM  = 4'h8;
   localparam logic [3:0] c_A_STATUS = 4'hC;

   logic        i_clock;
   logic        i_reset;
   logic [7:0]  i_sources;
   logic        i_request;
   logic        i_rw;
   logic [3:0]  i_address;
   logic [31:0] i_wdata;
   logic [31:0] o_rdata;
   logic        o_ready;
   logic        o_interrupt;

   int n_checks;
   int n_pass;

   cpu_irq_arbiter #(.SOURCES(8)) u_dut (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_sources   (i_sources),
      .i_request   (i_request),
      .i_rw        (i_rw),
      .i_address   (i_address),
      .i_wdata     (i_wdata),
      .o_rdata     (o_rdata),
      .o_ready     (o_ready),
      .o_interrupt (o_interrupt)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at a negedge with the bus idle again.
   task automatic bus(input logic rw, input logic [3:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd);
      int n;
      i_request = 1'b1;
      i_rw      = rw;
      i_address = addr;
      i_wdata   = wd;
      n = 0;
      do begin
         @(negedge i_clock);
         n++;
      end while (!o_ready && n < 10);
      if (!o_ready) check("bus_timeout", {31'd0, o_ready}, 32'd1);
      rd        = o_rdata;
      i_request = 1'b0;
      @(negedge i_clock);
   endtask

   task automatic wr(input logic [3:0] addr, input logic [31:0] wd);
      logic [31:0] d;
      bus(1'b1, addr, wd, d);
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      bus(1'b0, addr, 32'd0, d);
      check(tag, d, exp);
   endtask

   task automatic pulse(input logic [7:0] m);
      i_sources = i_sources | m;
      repeat (4) @(negedge i_clock);
      i_sources = i_sources & ~m;
      repeat (3) @(negedge i_clock);
   endtask

   task automatic do_reset();
      i_reset   = 1'b0;
      i_request = 1'b0;
      i_sources = '0;
      repeat (3) @(negedge i_clock);
      i_reset = 1'b1;
      @(negedge i_clock);
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      i_reset   = 1'b0;
      i_request = 1'b0;
      i_rw      = 1'b0;
      i_address = '0;
      i_wdata   = '0;
      i_sources = '0;

      // 1. Reset state
      repeat (2) @(negedge i_clock);
      check("rst_ready", {31'd0, o_ready}, 32'd0);
      check("rst_irq", {31'd0, o_interrupt}, 32'd0);
      check("rst_rdata", o_rdata, 32'd0);
      i_reset = 1'b1;
      @(negedge i_clock);
      rd_chk("rst_pending", c_A_PEND, 32'd0);
      rd_chk("rst_enable", c_A_EN, 32'd0);
      rd_chk("rst_status", c_A_STATUS, 32'd0);
      rd_chk("rst_claim", c_A_CLAIM, 32'd0);
      rd_chk("rst_status2", c_A_STATUS, 32'd0);

      // 2. Single source, latency, claim and complete
      wr(c_A_EN, 32'h04);
      i_sources[2] = 1'b1;
      repeat (3) @(negedge i_clock);
      check("t2_irq_early", {31'd0, o_interrupt}, 32'd0);
      @(negedge i_clock);
      check("t2_irq_4cyc", {31'd0, o_interrupt}, 32'd1);
      i_sources[2] = 1'b0;
      repeat (2) @(negedge i_clock);
      rd_chk("t2_claim", c_A_CLAIM, 32'd3);
      check("t2_irq_off", {31'd0, o_interrupt}, 32'd0);
      rd_chk("t2_status", c_A_STATUS, 32'h8000_0003);
      rd_chk("t2_pending", c_A_PEND, 32'd0);
      wr(c_A_CLAIM, 32'd3);
      rd_chk("t2_status_done", c_A_STATUS, 32'd0);

      // 3. Round-robin from a fresh pointer, then wrap
      do_reset();
      wr(c_A_EN, 32'hFFFF_FFFF);
      rd_chk("t3_enable_mask", c_A_EN, 32'h0000_00FF);
      pulse(8'h62);
      rd_chk("t3_pending", c_A_PEND, 32'h62);
      rd_chk("t3_claim_a", c_A_CLAIM, 32'd2);
      wr(c_A_CLAIM, 32'd2);
      rd_chk("t3_claim_b", c_A_CLAIM, 32'd6);
      wr(c_A_CLAIM, 32'd6);
      rd_chk("t3_claim_c", c_A_CLAIM, 32'd7);
      wr(c_A_CLAIM, 32'd7);
      pulse(8'h22);
      rd_chk("t3_wrap_first", c_A_CLAIM, 32'd2);
      wr(c_A_CLAIM, 32'd2);
      rd_chk("t3_wrap_second", c_A_CLAIM, 32'd6);
      wr(c_A_CLAIM, 32'd6);

      // 4. Claim refused while in service; wrong complete ignored
      pulse(8'h02);
      rd_chk("t4_claim", c_A_CLAIM, 32'd2);
      pulse(8'h10);
      check("t4_irq_blocked", {31'd0, o_interrupt}, 32'd0);
      rd_chk("t4_claim_refused", c_A_CLAIM, 32'd0);
      rd_chk("t4_pending4", c_A_PEND, 32'h10);
      wr(c_A_CLAIM, 32'd5);
      rd_chk("t4_status_kept", c_A_STATUS, 32'h8000_0002);
      wr(c_A_CLAIM, 32'd2);
      check("t4_irq_reassert", {31'd0, o_interrupt}, 32'd1);
      rd_chk("t4_claim5", c_A_CLAIM, 32'd5);
      wr(c_A_CLAIM, 32'd5);
      rd_chk("t4_status_clear", c_A_STATUS, 32'd0);

      // 5. Disabled source keeps pending; W1C vs coincident edge
      wr(c_A_EN, 32'd0);
      pulse(8'h01);
      check("t5_irq_disabled", {31'd0, o_interrupt}, 32'd0);
      rd_chk("t5_pending", c_A_PEND, 32'h1);
      rd_chk("t5_claim_none", c_A_CLAIM, 32'd0);
      wr(c_A_PEND, 32'h1);
      rd_chk("t5_w1c", c_A_PEND, 32'd0);
      i_sources[0] = 1'b1;
      repeat (2) @(negedge i_clock);
      wr(c_A_PEND, 32'h1);
      i_sources[0] = 1'b0;
      rd_chk("t5_edge_wins", c_A_PEND, 32'h1);
      repeat (3) @(negedge i_clock);
      wr(c_A_PEND, 32'h1);
      rd_chk("t5_cleared", c_A_PEND, 32'd0);

      // 6. Held request: single side effect; async reset during ACK
      wr(c_A_EN, 32'h08);
      pulse(8'h08);
      i_request = 1'b1;
      i_rw      = 1'b0;
      i_address = c_A_CLAIM;
      @(negedge i_clock);
      for (int k = 0; k < 5; k++) begin
         check("t6_ready_held", {31'd0, o_ready}, 32'd1);
         check("t6_rdata_held", o_rdata, 32'd4);
         @(negedge i_clock);
      end
      i_request = 1'b0;
      @(negedge i_clock);
      check("t6_ready_drop", {31'd0, o_ready}, 32'd0);
      rd_chk("t6_status", c_A_STATUS, 32'h8000_0004);
      rd_chk("t6_pending", c_A_PEND, 32'd0);
      i_request = 1'b1;
      i_address = c_A_STATUS;
      @(negedge i_clock);
      check("t6_ack", {31'd0, o_ready}, 32'd1);
      #2 i_reset = 1'b0;
      #1;
      check("t6_async_ready", {31'd0, o_ready}, 32'd0);
      check("t6_async_rdata", o_rdata, 32'd0);
      @(negedge i_clock);
      i_request = 1'b0;
      i_reset   = 1'b1;
      @(negedge i_clock);
      rd_chk("t6_status_reset", c_A_STATUS, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
